// File: rtl/rgb_pwm_breathe.sv
// rgb_pwm_breathe: CH-channel PWM with off / fixed / triangle / sawtooth duty modes.
// Define RGB_PWM_STAGGER_EN to offset channel i counter origin by i quarter periods.
module rgb_pwm_breathe #(
    parameter int CH       = 3,
    parameter int CNT_W    = 13,
    parameter int STEP_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_edge,
    input  logic                  load,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH*CNT_W-1:0]   duty,
    output logic [CH-1:0]         pwm_out,
    output logic [CH-1:0]         period_tick,
    output logic [CH-1:0]         peak
);

    localparam logic [CNT_W-1:0] DMAX = {CNT_W{1'b1}};
    localparam int PW = $clog2(STEP_DIV << (CH - 1)) + 1;

    typedef enum logic [1:0] {
        M_OFF = 2'b00,
        M_FIX = 2'b01,
        M_TRI = 2'b10,
        M_SAW = 2'b11
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    logic [2*CH-1:0]     smode_q;
    logic [CH*CNT_W-1:0] sduty_q;

    // Shadow registers capture every channel's mode and duty on load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smode_q <= '0;
            sduty_q <= '0;
        end else if (load) begin
            smode_q <= mode;
            sduty_q <= duty;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch

`ifdef RGB_PWM_STAGGER_EN
        localparam logic [CNT_W-1:0] ORIGIN = CNT_W'(g * (2 ** (CNT_W - 2)));
`else
        localparam logic [CNT_W-1:0] ORIGIN = '0;
`endif
        localparam logic [PW-1:0] PLAST = PW'((STEP_DIV << g) - 1);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] d_q, d_d;
        dir_e             dir_q, dir_d;
        logic [PW-1:0]    presc_q, presc_d;
        mode_e            amode_q, amode_d;
        logic             pend_q, pend_d;
        logic             pwm_q, pwm_d;
        logic             tick_q, tick_d;
        logic             peak_q, peak_d;

        mode_e            smode;
        logic [CNT_W-1:0] sduty;
        logic [CNT_W-1:0] d_inc;
        logic [CNT_W-1:0] d_dec;
        logic             bnd;
        logic             step;

        // Next state: restart, boundary apply/step, or free-running count
        always_comb begin
            smode   = mode_e'(smode_q[2*g +: 2]);
            sduty   = sduty_q[g*CNT_W +: CNT_W];
            d_inc   = d_q + CNT_W'(1);
            d_dec   = d_q - CNT_W'(1);
            bnd     = (cnt_q == DMAX);
            step    = (presc_q == PLAST);
            cnt_d   = cnt_q + CNT_W'(1);
            d_d     = d_q;
            dir_d   = dir_q;
            presc_d = presc_q;
            amode_d = amode_q;
            pend_d  = load | (pend_q & ~(bnd & ~f_edge));
            pwm_d   = (amode_q != M_OFF) && (cnt_q < d_q);
            tick_d  = bnd;
            peak_d  = 1'b0;
            if (f_edge) begin
                cnt_d   = ORIGIN;
                presc_d = '0;
                dir_d   = UP;
                if (amode_q == M_TRI || amode_q == M_SAW) begin
                    d_d = '0;
                end
                pwm_d  = 1'b0;
                tick_d = 1'b0;
            end else if (bnd) begin
                amode_d = smode;
                if (pend_q || smode != amode_q) begin
                    d_d     = (smode == M_OFF) ? '0 : sduty;
                    dir_d   = UP;
                    presc_d = '0;
                end else begin
                    unique case (amode_q)
                        M_OFF: d_d = '0;
                        M_FIX: d_d = d_q;
                        M_TRI, M_SAW: begin
                            presc_d = step ? '0 : presc_q + PW'(1);
                            if (step) begin
                                if (amode_q == M_SAW) begin
                                    d_d    = d_inc;
                                    peak_d = (d_inc == DMAX);
                                end else if (dir_q == UP && d_q != DMAX) begin
                                    d_d = d_inc;
                                    if (d_inc == DMAX) begin
                                        dir_d  = DOWN;
                                        peak_d = 1'b1;
                                    end
                                end else begin
                                    d_d   = d_dec;
                                    dir_d = (d_dec == '0) ? UP : DOWN;
                                end
                            end
                        end
                    endcase
                end
            end
        end

        // Channel state registers
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q   <= ORIGIN;
                d_q     <= '0;
                dir_q   <= UP;
                presc_q <= '0;
                amode_q <= M_OFF;
                pend_q  <= 1'b0;
                pwm_q   <= 1'b0;
                tick_q  <= 1'b0;
                peak_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                d_q     <= d_d;
                dir_q   <= dir_d;
                presc_q <= presc_d;
                amode_q <= amode_d;
                pend_q  <= pend_d;
                pwm_q   <= pwm_d;
                tick_q  <= tick_d;
                peak_q  <= peak_d;
            end
        end

        assign pwm_out[g]     = pwm_q;
        assign period_tick[g] = tick_q;
        assign peak[g]        = peak_q;
    end

endmodule

// File: tb/tb_rgb_pwm_breathe.sv
// tb_rgb_pwm_breathe: directed table, hand sequences and random stimulus
// against a closed-form duty model for rgb_pwm_breathe (CH=3, CNT_W=4).
module tb_rgb_pwm_breathe;

    localparam int CH       = 3;
    localparam int CNT_W    = 4;
    localparam int STEP_DIV = 1;
    localparam int DMAX     = 15;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        f_edge = 1'b0;
    logic        load   = 1'b0;
    logic [5:0]  mode   = '0;
    logic [11:0] duty   = '0;
    logic [2:0]  pwm_out;
    logic [2:0]  period_tick;
    logic [2:0]  peak;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_pwm_breathe #(
        .CH(CH),
        .CNT_W(CNT_W),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .f_edge(f_edge),
        .load(load),
        .mode(mode),
        .duty(duty),
        .pwm_out(pwm_out),
        .period_tick(period_tick),
        .peak(peak)
    );

    // Reference model: phase counter plus duty as a closed-form function of
    // start value and number of breathe steps taken since apply/restart.
    int ph [CH];
    int act [CH];
    int st [CH];
    int np [CH];
    bit pend [CH];
    int sm [CH];
    int sd [CH];
    logic [2:0] e_pwm  = '0;
    logic [2:0] e_tick = '0;
    logic [2:0] e_peak = '0;

    function automatic int origin(int i);
`ifdef RGB_PWM_STAGGER_EN
        return (i * (1 << (CNT_W - 2))) % (1 << CNT_W);
`else
        return 0 * i;
`endif
    endfunction

    function automatic int dval(int i);
        int n;
        int p;
        n = np[i] / (STEP_DIV << i);
        case (act[i])
            0: return 0;
            1: return st[i];
            2: begin
                p = (st[i] + n) % (2 * DMAX);
                return (p <= DMAX) ? p : 2 * DMAX - p;
            end
            default: return (st[i] + n) % (DMAX + 1);
        endcase
    endfunction

    task automatic model_edge();
        for (int i = 0; i < CH; i++) begin
            int dv;
            bit bnd;
            if (!rst_n) begin
                ph[i] = origin(i);
                act[i] = 0; st[i] = 0; np[i] = 0; pend[i] = 0;
                sm[i] = 0; sd[i] = 0;
                e_pwm[i] = 1'b0; e_tick[i] = 1'b0; e_peak[i] = 1'b0;
            end else begin
                dv = dval(i);
                bnd = (ph[i] == DMAX);
                e_pwm[i]  = (act[i] != 0) && (ph[i] < dv);
                e_tick[i] = bnd;
                e_peak[i] = 1'b0;
                if (f_edge) begin
                    ph[i] = origin(i);
                    np[i] = 0;
                    if (act[i] >= 2) st[i] = 0;
                    e_pwm[i]  = 1'b0;
                    e_tick[i] = 1'b0;
                end else if (bnd) begin
                    ph[i] = 0;
                    if (pend[i] || sm[i] != act[i]) begin
                        act[i] = sm[i];
                        st[i] = (sm[i] == 0) ? 0 : sd[i];
                        np[i] = 0;
                    end else if (act[i] >= 2) begin
                        np[i]++;
                        if (np[i] % (STEP_DIV << i) == 0 && dval(i) == DMAX)
                            e_peak[i] = 1'b1;
                    end
                end else begin
                    ph[i]++;
                end
                pend[i] = load || (pend[i] && !(bnd && !f_edge));
                if (load) begin
                    sm[i] = int'(mode[2*i +: 2]);
                    sd[i] = int'(duty[4*i +: 4]);
                end
            end
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if (pwm_out !== e_pwm || period_tick !== e_tick || peak !== e_peak) begin
            errors++;
            $display("FAIL model t=%0t pwm=%b exp=%b tick=%b exp=%b peak=%b exp=%b",
                     $time, pwm_out, e_pwm, period_tick, e_tick, peak, e_peak);
        end
    endtask

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load   = 1'($urandom_range(0, 1));
            f_edge = 1'($urandom_range(0, 1));
            mode   = 6'($urandom);
            duty   = 12'($urandom);
            clk_step();
            chk("reset_outputs", int'({pwm_out, period_tick, peak}), 0);
        end
        load   = 1'b0;
        f_edge = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic wait_tick0(string name);
        int n;
        n = 0;
        while (!period_tick[0] && n < 40) begin
            clk_step();
            n++;
        end
        chk(name, int'(period_tick[0]), 1);
    endtask

    // Counts pwm highs per channel and ch0 peaks over one 16-clock window
    task automatic count_win(output int h [CH], output int pk);
        for (int i = 0; i < CH; i++) h[i] = 0;
        pk = 0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < CH; i++) h[i] += int'(pwm_out[i]);
            pk += int'(peak[0]);
            clk_step();
        end
    endtask

    typedef struct {
        logic [5:0]  mode;
        logic [11:0] duty;
        int          e0 [8];
        int          e1 [8];
        int          e2 [8];
        int          peaks;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int h [CH];
        int pk;
        int pks;
        int first [CH];
        int n;
        int hi;

        tbl[0].mode = 6'b000001; tbl[0].duty = 12'h005; tbl[0].peaks = 0;
        tbl[0].e0 = '{5, 5, 5, 5, 5, 5, 5, 5};
        tbl[0].e1 = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].e2 = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].mode = 6'b000011; tbl[1].duty = 12'h00E; tbl[1].peaks = 1;
        tbl[1].e0 = '{14, 15, 0, 1, 2, 3, 4, 5};
        tbl[1].e1 = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].e2 = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].mode = 6'b101010; tbl[2].duty = 12'h000; tbl[2].peaks = 0;
        tbl[2].e0 = '{0, 1, 2, 3, 4, 5, 6, 7};
        tbl[2].e1 = '{0, 0, 1, 1, 2, 2, 3, 3};
        tbl[2].e2 = '{0, 0, 0, 0, 1, 1, 1, 1};
        tbl[3].mode = 6'b000010; tbl[3].duty = 12'h00F; tbl[3].peaks = 0;
        tbl[3].e0 = '{15, 14, 13, 12, 11, 10, 9, 8};
        tbl[3].e1 = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].e2 = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].mode = 6'b110110; tbl[4].duty = 12'hFFD; tbl[4].peaks = 1;
        tbl[4].e0 = '{13, 14, 15, 14, 13, 12, 11, 10};
        tbl[4].e1 = '{15, 15, 15, 15, 15, 15, 15, 15};
        tbl[4].e2 = '{15, 15, 15, 15, 0, 0, 0, 0};

        // Reset and first period_tick timing
        do_reset();
        for (int i = 0; i < CH; i++) first[i] = 0;
        for (int k = 1; k <= 40; k++) begin
            clk_step();
            for (int i = 0; i < CH; i++)
                if (first[i] == 0 && period_tick[i]) first[i] = k;
        end
        for (int i = 0; i < CH; i++)
            chk($sformatf("first_tick ch%0d", i), first[i],
                ((DMAX - origin(i)) % (DMAX + 1)) + 1);

        // Table-driven mode/duty sequences, eight periods each
        for (int r = 0; r < 5; r++) begin
            do_reset();
            repeat (3) clk_step();
            mode = tbl[r].mode;
            duty = tbl[r].duty;
            load = 1'b1;
            clk_step();
            load = 1'b0;
            wait_tick0($sformatf("row%0d_tick", r));
            pks = 0;
            for (int k = 0; k < 8; k++) begin
                count_win(h, pk);
                pks += pk;
                chk($sformatf("row%0d ch0 period%0d duty", r, k), h[0], tbl[r].e0[k]);
`ifndef RGB_PWM_STAGGER_EN
                chk($sformatf("row%0d ch1 period%0d duty", r, k), h[1], tbl[r].e1[k]);
                chk($sformatf("row%0d ch2 period%0d duty", r, k), h[2], tbl[r].e2[k]);
`endif
            end
            chk($sformatf("row%0d ch0 peaks", r), pks, tbl[r].peaks);
        end

        // Load on a boundary cycle applies one period later
        do_reset();
        mode = 6'b000001;
        duty = 12'h003;
        load = 1'b1;
        clk_step();
        load = 1'b0;
        wait_tick0("bnd_first_tick");
        repeat (15) clk_step();
        duty = 12'h009;
        load = 1'b1;
        clk_step();
        load = 1'b0;
        chk("bnd_tick", int'(period_tick[0]), 1);
        count_win(h, pk);
        chk("bnd_old_duty", h[0], 3);
        count_win(h, pk);
        chk("bnd_new_duty", h[0], 9);

        // f_edge while ch0 triangle is descending at duty 9
        do_reset();
        mode = 6'b000010;
        duty = 12'h00F;
        load = 1'b1;
        clk_step();
        load = 1'b0;
        wait_tick0("fedge_first_tick");
        repeat (96) clk_step();
        repeat (5) clk_step();
        f_edge = 1'b1;
        clk_step();
        f_edge = 1'b0;
        chk("fedge_pwm_low", int'(pwm_out[0]), 0);
        hi = 0;
        n = 0;
        do begin
            hi += int'(pwm_out[0]);
            clk_step();
            n++;
        end while (!period_tick[0] && n < 40);
        chk("fedge_restart_len", n, 16);
        chk("fedge_restart_duty", hi, 0);
        count_win(h, pk);
        chk("fedge_up1", h[0], 1);
        count_win(h, pk);
        chk("fedge_up2", h[0], 2);

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 6000; k++) begin
            rst_n  = ($urandom_range(0, 999) != 0);
            f_edge = ($urandom_range(0, 149) == 0);
            load   = ($urandom_range(0, 24) == 0);
            mode   = 6'($urandom);
            duty   = 12'($urandom);
            if ($urandom_range(0, 3) == 0) duty = 12'hFEF;
            clk_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
